adder_sum_accumulator: RTL and testbench



---
 rtl/adder_sum_accumulator_pkg.sv | 20 ++
 rtl/adder_sum_accumulator.sv | 100 ++++++++++
 tb/tb_adder_sum_accumulator.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/adder_sum_accumulator_pkg.sv
// Shared defaults and helpers for the adder sum accumulator.
// The WIDTH default matches the 32-bit adder's registered sum.
package adder_sum_accumulator_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_ACC_WIDTH = 40;
    localparam int DEF_FRAME_LEN = 4;

    // ACCUM collects sums; HOLD means a frame total is waiting on the output.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } ctrl_state_e;

    // Frame counter width, kept at least one bit so FRAME_LEN=1 still builds.
    function automatic int count_width(input int frame_len);
        return (frame_len <= 1) ? 1 : $clog2(frame_len);
    endfunction

endpackage

// File: rtl/adder_sum_accumulator.sv
// Accumulates FRAME_LEN adder sums into one wide total with a per-frame carry flag.
// The total is offered on a valid/ready output, and back-pressure stalls the input.
module adder_sum_accumulator
    import adder_sum_accumulator_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    input  logic                 frame_clear,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf,
    input  logic                 out_ready
);

    localparam int               COUNT_W    = count_width(FRAME_LEN);
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(FRAME_LEN - 1);

    ctrl_state_e            state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0]     count_q, count_d;
    logic                   frame_ovf_q, frame_ovf_d;
    logic [ACC_WIDTH-1:0]   out_data_q, out_data_d;
    logic                   out_ovf_q, out_ovf_d;

    logic                   accept;
    logic                   pop;
    logic [ACC_WIDTH:0]     sum_next;
    logic                   carry;

    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    // A waiting total only blocks input if the consumer is not taking it now.
    assign in_ready = !frame_clear && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    assign sum_next = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, in_data};
    assign carry    = sum_next[ACC_WIDTH];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        frame_ovf_d = frame_ovf_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;

        if (pop) begin
            state_d = ACCUM;
        end

        // Completion after a pop in the same cycle re-arms HOLD with no bubble.
        if (frame_clear) begin
            acc_d       = '0;
            count_d     = '0;
            frame_ovf_d = 1'b0;
        end else if (accept) begin
            if (count_q == LAST_COUNT) begin
                out_data_d  = sum_next[ACC_WIDTH-1:0];
                out_ovf_d   = frame_ovf_q | carry;
                state_d     = HOLD;
                acc_d       = '0;
                count_d     = '0;
                frame_ovf_d = 1'b0;
            end else begin
                acc_d       = sum_next[ACC_WIDTH-1:0];
                count_d     = count_q + COUNT_W'(1);
                frame_ovf_d = frame_ovf_q | carry;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            frame_ovf_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            frame_ovf_q <= frame_ovf_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench for adder_sum_accumulator: a default-width instance plus a
// 33-bit accumulator instance fed from the same stimulus to exercise carry out.
module tb_adder_sum_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        frame_clear;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [39:0] out_data;
    logic        out_ovf;

    logic        in_ready33;
    logic        out_valid33;
    logic [32:0] out_data33;
    logic        out_ovf33;

    int errors;
    int checks;

    adder_sum_accumulator #(.WIDTH(32), .ACC_WIDTH(40), .FRAME_LEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .frame_clear(frame_clear),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .out_ready  (out_ready)
    );

    adder_sum_accumulator #(.WIDTH(32), .ACC_WIDTH(33), .FRAME_LEN(4)) dut33 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready33),
        .frame_clear(frame_clear),
        .out_valid  (out_valid33),
        .out_data   (out_data33),
        .out_ovf    (out_ovf33),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [31:0] d,
                                 input logic clr, input logic ordy);
        in_valid    = v;
        in_data     = d;
        frame_clear = clr;
        out_ready   = ordy;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sum that must be accepted this cycle, then advance a clock.
    task automatic sendSum(input string tag, input logic [31:0] d, input logic ordy);
        applyStimulus(1'b1, d, 1'b0, ordy);
        #1;
        checkOutput(tag, 64'(in_ready), 64'd1);
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_out_ovf", 64'(out_ovf), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        tick();

        $display("[TB] basic frame");
        sendSum("t1_rdy_a", 32'd1926, 1'b1);
        sendSum("t1_rdy_b", 32'd817, 1'b1);
        sendSum("t1_rdy_c", 32'd0, 1'b1);
        checkOutput("t1_no_early_valid", 64'(out_valid), 64'd0);
        sendSum("t1_rdy_d", 32'd1, 1'b1);
        checkOutput("t1_valid", 64'(out_valid), 64'd1);
        checkOutput("t1_data", 64'(out_data), 64'd2744);
        checkOutput("t1_ovf", 64'(out_ovf), 64'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        tick();
        checkOutput("t1_popped", 64'(out_valid), 64'd0);
        checkOutput("t1_data_kept", 64'(out_data), 64'd2744);

        $display("[TB] back-pressure");
        sendSum("t2_rdy_a", 32'd5, 1'b0);
        sendSum("t2_rdy_b", 32'd6, 1'b0);
        sendSum("t2_rdy_c", 32'd7, 1'b0);
        sendSum("t2_rdy_d", 32'd8, 1'b0);
        checkOutput("t2_valid", 64'(out_valid), 64'd1);
        checkOutput("t2_data", 64'(out_data), 64'd26);
        applyStimulus(1'b1, 32'd100, 1'b0, 1'b0);
        #1;
        checkOutput("t2_stall_ready", 64'(in_ready), 64'd0);
        tick();
        checkOutput("t2_hold_valid", 64'(out_valid), 64'd1);
        checkOutput("t2_hold_data", 64'(out_data), 64'd26);
        sendSum("t2_release_ready", 32'd100, 1'b1);
        checkOutput("t2_popped", 64'(out_valid), 64'd0);
        sendSum("t2_rdy_e", 32'd1, 1'b1);
        sendSum("t2_rdy_f", 32'd2, 1'b1);
        sendSum("t2_rdy_g", 32'd3, 1'b1);
        checkOutput("t2_next_valid", 64'(out_valid), 64'd1);
        checkOutput("t2_next_data", 64'(out_data), 64'd106);

        $display("[TB] streaming");
        for (int i = 0; i < 8; i++) begin
            sendSum("t3_rdy", 32'd1, 1'b1);
            checkOutput("t3_valid", 64'(out_valid), ((i == 3) || (i == 7)) ? 64'd1 : 64'd0);
        end
        checkOutput("t3_data", 64'(out_data), 64'd4);

        $display("[TB] overflow");
        for (int i = 0; i < 4; i++) begin
            sendSum("t4_rdy", 32'hFFFF_FFFF, 1'b1);
        end
        checkOutput("t4_valid33", 64'(out_valid33), 64'd1);
        checkOutput("t4_data33", 64'(out_data33), 64'h1_FFFF_FFFC);
        checkOutput("t4_ovf33", 64'(out_ovf33), 64'd1);
        checkOutput("t4_data40", 64'(out_data), 64'h3_FFFF_FFFC);
        checkOutput("t4_ovf40", 64'(out_ovf), 64'd0);
        for (int i = 0; i < 4; i++) begin
            sendSum("t4_rdy_ones", 32'd1, 1'b1);
        end
        checkOutput("t4_ones_data33", 64'(out_data33), 64'd4);
        checkOutput("t4_ones_ovf33", 64'(out_ovf33), 64'd0);
        checkOutput("t4_ones_ready33", 64'(in_ready33), 64'd1);

        $display("[TB] frame clear");
        sendSum("t5_rdy_a", 32'd10, 1'b1);
        sendSum("t5_rdy_b", 32'd20, 1'b1);
        applyStimulus(1'b1, 32'd99, 1'b1, 1'b1);
        #1;
        checkOutput("t5_clear_ready", 64'(in_ready), 64'd0);
        tick();
        sendSum("t5_rdy_c", 32'd3, 1'b1);
        sendSum("t5_rdy_d", 32'd4, 1'b1);
        sendSum("t5_rdy_e", 32'd5, 1'b1);
        sendSum("t5_rdy_f", 32'd6, 1'b1);
        checkOutput("t5_valid", 64'(out_valid), 64'd1);
        checkOutput("t5_data", 64'(out_data), 64'd18);

        $display("[TB] async reset");
        sendSum("t6_rdy_a", 32'd7, 1'b1);
        sendSum("t6_rdy_b", 32'd7, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        #3 rst = 1'b1;
        #1;
        checkOutput("t6_mid_valid", 64'(out_valid), 64'd0);
        checkOutput("t6_mid_data", 64'(out_data), 64'd0);
        tick();
        rst = 1'b0;
        sendSum("t6_rdy_c", 32'd1, 1'b1);
        sendSum("t6_rdy_d", 32'd2, 1'b1);
        sendSum("t6_rdy_e", 32'd3, 1'b1);
        sendSum("t6_rdy_f", 32'd4, 1'b1);
        checkOutput("t6_valid", 64'(out_valid), 64'd1);
        checkOutput("t6_data", 64'(out_data), 64'd10);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        checkOutput("t6_pending_valid", 64'(out_valid), 64'd1);
        #3 rst = 1'b1;
        #1;
        checkOutput("t6_pend_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("t6_pend_rst_data", 64'(out_data), 64'd0);
        checkOutput("t6_pend_rst_ovf", 64'(out_ovf), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("t6_post_ready", 64'(in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
